cir_os_dec: RTL and testbench
=============================

// Module: cir_os_dec
// PURPOSE
//  Receive-side decoder for the 2-bit oscillator code stream (states 00/01/10/11).
//  - Per valid sample, compares the current code with the previous one and recovers control bit A:
//    - bit0-only flip (00<->01, 10<->11): A=0.
//    - bit1-only flip (00<->10, 01<->11): A=1.
//  - Same code, or both bits flipped: illegal step.
//  - Lock FSM qualifies the stream; in lock, the block delivers recovered A and counts errors.
// PARAMETERS
//  LOCK_N  4  consecutive legal steps needed to enter LOCK (>=1)
//  LOSS_N  2  consecutive illegal steps in LOCK that drop back to CHECK (>=1)
//  CNT_W   8  width of err_cnt
// PORTS
//  clk       in   1      clock; all flops rise on posedge
//  rst       in   1      asynchronous active-high reset
//  code_vld  in   1      code is a valid sample this cycle
//  code      in   2      oscillator state sample
//  x_out     out  1      recovered A (held between updates)
//  x_vld     out  1      1-cycle pulse: x_out updated from a legal step in LOCK
//  locked    out  1      FSM is in LOCK
//  err       out  1      1-cycle pulse: illegal step seen in LOCK
//  err_cnt   out  CNT_W  saturating count of err pulses
// BEHAVIOUR
//  - Reset values: all outputs 0; FSM=HUNT; prev=00; step cnt=0; miss cnt=0.
//  - Reset asserted mid-stream clears everything immediately, without waiting for clk.
//  - code_vld=0: no state, prev, counter or output change; x_vld and err are 0 that cycle.
//  - Step decode uses diff = prev ^ code:
//    - diff=01: legal, A=0.
//    - diff=10: legal, A=1.
//    - diff=00 or 11: illegal.
//  - prev<=code on every valid sample, legal or not.
//  - Latency: all outputs are registered and update at the edge that samples code_vld=1.
//  - FSM states:
//    - HUNT: no reference sample. First valid sample loads prev, goes to CHECK with cnt=0.
//      No step is decoded.
//    - CHECK: legal step increments cnt; illegal step clears cnt.
//      - When the LOCK_N-th consecutive legal step is sampled: go to LOCK, locked=1, cnt=0.
//      - x_vld, err and err_cnt do not move in CHECK.
//    - LOCK, legal step: x_out=A, x_vld=1, miss=0.
//    - LOCK, illegal step: err=1, x_vld=0, x_out holds, miss++, err_cnt++.
//      - When miss reaches LOSS_N: go to CHECK, locked=0, miss=0, cnt=0.
//      - The err pulse for that step still fires.
//  - err_cnt saturates at all-ones; only rst clears it.
//  - HUNT is entered only from reset. Loss of lock returns to CHECK, because prev is still valid.
// CONFIGURATION
//  - Macro CIR_OS_DEC_ERRCNT_EN defined: err_cnt counts as above.
//  - Macro undefined: the counter logic is not built and err_cnt is tied to 0.
//  - err pulse and lock/loss behaviour are identical either way.
// STRUCTURE
//  - Package cir_os_pkg holds:
//    - Code localparams ST_A=2'b00, ST_B=2'b01, ST_C=2'b10, ST_D=2'b11.
//    - Decoder FSM encoding: HUNT, CHECK, LOCK.
//    - Step-diff constants DIFF_A0=2'b01, DIFF_A1=2'b10.
//  - Sub-module cir_os_step_chk is combinational:
//    - Inputs prev[1:0], code[1:0].
//    - Outputs legal, a_bit.
//  - The lock FSM, counters and output registers stay in cir_os_dec.
// TESTING
//  - Reset, then 00,01,00,01,00 with code_vld=1 every cycle (LOCK_N=4):
//    - locked=1 at the 5th sample edge.
//    - x_vld stays 0 until locked.
//  - In lock, feed 00,10,11,01,00: x_vld=1 each cycle with x_out=1,0,1,0.
//  - In lock, illegal 01->01:
//    - err=1 for one cycle, err_cnt 0->1, locked stays 1.
//    - Next legal step clears miss.
//  - In lock, 00->11->00 (two illegal steps, LOSS_N=2):
//    - err pulses twice, locked=0 after the 2nd.
//    - Re-lock after 4 legal steps.
//  - Stall and reset:
//    - code_vld=0 for 3 cycles mid-lock: outputs hold, no err.
//    - Assert rst between clk edges: all outputs 0 immediately, FSM in HUNT.
//  - Saturation: with the macro defined and CNT_W=2, force 5 lock/err events.
//    - err_cnt sticks at 3.
//    - With the macro undefined, err_cnt stays 0.

Source files
------------

// File: rtl/cir_os_pkg.sv
// Shared constants and types for the oscillator-code receive decoder.
// Used by cir_os_step_chk and cir_os_dec.
package cir_os_pkg;

  localparam logic [1:0] ST_A = 2'b00;
  localparam logic [1:0] ST_B = 2'b01;
  localparam logic [1:0] ST_C = 2'b10;
  localparam logic [1:0] ST_D = 2'b11;

  localparam logic [1:0] DIFF_A0 = 2'b01;
  localparam logic [1:0] DIFF_A1 = 2'b10;

  typedef enum logic [1:0] {
    HUNT  = 2'b00,
    CHECK = 2'b01,
    LOCK  = 2'b10
  } dec_state_e;

  function automatic logic [1:0] step_diff(input logic [1:0] prev, input logic [1:0] code);
    return prev ^ code;
  endfunction

endpackage

// File: rtl/cir_os_step_chk.sv
// Combinational step classifier: a single-bit flip between consecutive codes is legal
// and its position carries control bit A.
module cir_os_step_chk
  import cir_os_pkg::*;
(
  input  logic [1:0] prev,
  input  logic [1:0] code,
  output logic       legal,
  output logic       a_bit
);

  logic [1:0] diff_s;

  assign diff_s = step_diff(prev, code);

  // Unchanged codes and double flips both carry no information.
  always_comb begin
    legal = 1'b0;
    a_bit = 1'b0;
    case (diff_s)
      DIFF_A0: begin
        legal = 1'b1;
        a_bit = 1'b0;
      end
      DIFF_A1: begin
        legal = 1'b1;
        a_bit = 1'b1;
      end
      default: begin
        legal = 1'b0;
        a_bit = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/cir_os_dec.sv
// Oscillator-code receive decoder: lock FSM, recovered bit A, error pulse and counter.
// Define CIR_OS_DEC_ERRCNT_EN to build the saturating err_cnt; otherwise err_cnt is tied to 0.
module cir_os_dec
  import cir_os_pkg::*;
#(
  parameter int LOCK_N = 4,
  parameter int LOSS_N = 2,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             code_vld,
  input  logic [1:0]       code,
  output logic             x_out,
  output logic             x_vld,
  output logic             locked,
  output logic             err,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int STEP_W = (LOCK_N < 2) ? 1 : $clog2(LOCK_N);
  localparam int MISS_W = (LOSS_N < 2) ? 1 : $clog2(LOSS_N);

  dec_state_e        state_q, state_d;
  logic [1:0]        prev_q, prev_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [MISS_W-1:0] miss_q, miss_d;
  logic              x_out_q, x_out_d;
  logic              x_vld_q, x_vld_d;
  logic              locked_q, locked_d;
  logic              err_q, err_d;
  logic              legal_s, a_bit_s;

  cir_os_step_chk u_step_chk (
    .prev  (prev_q),
    .code  (code),
    .legal (legal_s),
    .a_bit (a_bit_s)
  );

`ifdef CIR_OS_DEC_ERRCNT_EN
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
`endif

  // Counters hold the last terminal value minus one, so the match fires on the N-th event.
  always_comb begin
    state_d  = state_q;
    prev_d   = prev_q;
    step_d   = step_q;
    miss_d   = miss_q;
    x_out_d  = x_out_q;
    x_vld_d  = 1'b0;
    locked_d = locked_q;
    err_d    = 1'b0;
`ifdef CIR_OS_DEC_ERRCNT_EN
    err_cnt_d = err_cnt_q;
`endif
    if (code_vld) begin
      prev_d = code;
      case (state_q)
        HUNT: begin
          state_d = CHECK;
          step_d  = {STEP_W{1'b0}};
        end
        CHECK: begin
          if (!legal_s) begin
            step_d = {STEP_W{1'b0}};
          end else if (step_q == STEP_W'(LOCK_N - 1)) begin
            state_d  = LOCK;
            locked_d = 1'b1;
            step_d   = {STEP_W{1'b0}};
            miss_d   = {MISS_W{1'b0}};
          end else begin
            step_d = step_q + STEP_W'(1);
          end
        end
        LOCK: begin
          if (legal_s) begin
            x_out_d = a_bit_s;
            x_vld_d = 1'b1;
            miss_d  = {MISS_W{1'b0}};
          end else begin
            err_d = 1'b1;
`ifdef CIR_OS_DEC_ERRCNT_EN
            if (err_cnt_q != {CNT_W{1'b1}}) begin
              err_cnt_d = err_cnt_q + CNT_W'(1);
            end else begin
              err_cnt_d = err_cnt_q;
            end
`endif
            if (miss_q == MISS_W'(LOSS_N - 1)) begin
              state_d  = CHECK;
              locked_d = 1'b0;
              miss_d   = {MISS_W{1'b0}};
              step_d   = {STEP_W{1'b0}};
            end else begin
              miss_d = miss_q + MISS_W'(1);
            end
          end
        end
        default: begin
          state_d  = HUNT;
          locked_d = 1'b0;
          step_d   = {STEP_W{1'b0}};
          miss_d   = {MISS_W{1'b0}};
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= HUNT;
      prev_q   <= ST_A;
      step_q   <= {STEP_W{1'b0}};
      miss_q   <= {MISS_W{1'b0}};
      x_out_q  <= 1'b0;
      x_vld_q  <= 1'b0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      prev_q   <= prev_d;
      step_q   <= step_d;
      miss_q   <= miss_d;
      x_out_q  <= x_out_d;
      x_vld_q  <= x_vld_d;
      locked_q <= locked_d;
      err_q    <= err_d;
    end
  end

`ifdef CIR_OS_DEC_ERRCNT_EN
  // Error counter; only reset clears it, and it sticks at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt_q <= {CNT_W{1'b0}};
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;
`else
  assign err_cnt = {CNT_W{1'b0}};
`endif

  assign x_out  = x_out_q;
  assign x_vld  = x_vld_q;
  assign locked = locked_q;
  assign err    = err_q;

endmodule

// File: tb/tb_cir_os_dec.sv
// Scoreboard bench for cir_os_dec: directed scenarios plus randomized code streams
// checked against a behavioural model of the decoding rules.
module tb_cir_os_dec;

  localparam int LOCK_N = 4;
  localparam int LOSS_N = 2;
  localparam int CNT_W  = 2;
`ifdef CIR_OS_DEC_ERRCNT_EN
  localparam bit ERRCNT_EN = 1'b1;
`else
  localparam bit ERRCNT_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             code_vld;
  logic [1:0]       code;
  logic             x_out, x_vld, locked, err;
  logic [CNT_W-1:0] err_cnt;

  typedef struct packed {
    logic             x_out;
    logic             x_vld;
    logic             locked;
    logic             err;
    logic [CNT_W-1:0] err_cnt;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;

  // reference model state
  bit         m_have_ref, m_lock, m_xo;
  logic [1:0] m_prev;
  int         m_run_legal, m_run_bad, m_errc;

  cir_os_dec #(.LOCK_N(LOCK_N), .LOSS_N(LOSS_N), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .code_vld(code_vld), .code(code),
    .x_out(x_out), .x_vld(x_vld), .locked(locked), .err(err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic model_reset();
    m_have_ref  = 1'b0;
    m_lock      = 1'b0;
    m_xo        = 1'b0;
    m_prev      = 2'b00;
    m_run_legal = 0;
    m_run_bad   = 0;
    m_errc      = 0;
  endtask

  task automatic check(input string name, input exp_t got, input exp_t want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s cyc=%0d got x_out=%b x_vld=%b locked=%b err=%b err_cnt=%0d, required x_out=%b x_vld=%b locked=%b err=%b err_cnt=%0d",
               name, cyc, got.x_out, got.x_vld, got.locked, got.err, got.err_cnt,
               want.x_out, want.x_vld, want.locked, want.err, want.err_cnt);
    end
  endtask

  // Drive one sample and push the response the model predicts for the next edge.
  task automatic step(input bit vld, input logic [1:0] c);
    exp_t e;
    bit   f0, f1, good;
    @(negedge clk);
    code_vld = vld;
    code     = c;
    e = '0;
    if (vld) begin
      if (!m_have_ref) begin
        m_have_ref  = 1'b1;
        m_run_legal = 0;
      end else begin
        f0   = (m_prev[0] != c[0]);
        f1   = (m_prev[1] != c[1]);
        good = (f0 != f1);
        if (!m_lock) begin
          m_run_legal = good ? m_run_legal + 1 : 0;
          if (m_run_legal == LOCK_N) begin
            m_lock      = 1'b1;
            m_run_legal = 0;
            m_run_bad   = 0;
          end
        end else if (good) begin
          m_xo      = f1;
          e.x_vld   = 1'b1;
          m_run_bad = 0;
        end else begin
          e.err = 1'b1;
          if (ERRCNT_EN && m_errc < (1 << CNT_W) - 1) m_errc++;
          m_run_bad++;
          if (m_run_bad == LOSS_N) begin
            m_lock      = 1'b0;
            m_run_bad   = 0;
            m_run_legal = 0;
          end
        end
      end
      m_prev = c;
    end
    e.x_out   = m_xo;
    e.locked  = m_lock;
    e.err_cnt = CNT_W'(m_errc);
    exp_q.push_back(e);
  endtask

  // Monitor: compare every registered response shortly after the edge that produced it.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("out", {x_out, x_vld, locked, err, err_cnt}, e);
      end
    end
  end

  task automatic async_reset_check();
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("async_rst", {x_out, x_vld, locked, err, err_cnt}, '0);
    code_vld = 1'b1;
    code     = 2'b01;
    @(posedge clk);
    #1;
    check("rst_hold", {x_out, x_vld, locked, err, err_cnt}, '0);
    @(negedge clk);
    code_vld = 1'b0;
    rst      = 1'b0;
    model_reset();
  endtask

  initial begin
    logic [1:0] nc;
    int         r;
    rst      = 1'b1;
    code_vld = 1'b0;
    code     = 2'b00;
    model_reset();
    #1;
    check("reset", {x_out, x_vld, locked, err, err_cnt}, '0);
    @(negedge clk);
    rst = 1'b0;

    // acquire lock, then A=1,0,1,0
    step(1'b1, 2'b00); step(1'b1, 2'b01); step(1'b1, 2'b00); step(1'b1, 2'b01); step(1'b1, 2'b00);
    step(1'b1, 2'b10); step(1'b1, 2'b11); step(1'b1, 2'b01); step(1'b1, 2'b00);
    // single illegal step, recovered by a legal one
    step(1'b1, 2'b01); step(1'b1, 2'b01); step(1'b1, 2'b00);
    // stall mid-lock
    step(1'b0, 2'b11); step(1'b0, 2'b10); step(1'b0, 2'b01);
    // two illegal steps drop lock, then re-lock
    step(1'b1, 2'b11); step(1'b1, 2'b00);
    step(1'b1, 2'b01); step(1'b1, 2'b00); step(1'b1, 2'b01); step(1'b1, 2'b00);
    // more errors to reach counter saturation
    step(1'b1, 2'b00); step(1'b1, 2'b01); step(1'b1, 2'b01); step(1'b1, 2'b11);
    step(1'b1, 2'b01); step(1'b1, 2'b11); step(1'b1, 2'b11);

    async_reset_check();

    for (int i = 0; i < 800; i++) begin
      r = $urandom_range(0, 99);
      if (r < 85) nc = m_prev ^ (($urandom_range(0, 1) != 0) ? 2'b10 : 2'b01);
      else if (r < 93) nc = m_prev;
      else nc = m_prev ^ 2'b11;
      step($urandom_range(0, 9) != 0, nc);
      if (i == 400) async_reset_check();
    end

    repeat (3) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain left=%0d required=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
